// File: rtl/adc_zero_cal_ctrl.sv
// ADC zero-level calibration controller. It stops the modulation path, lets the
// pipeline drain, then averages 2^k samples of one channel and commits the mean.
module adc_zero_cal_ctrl #(
  parameter int ADC_WIDTH    = 12,
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_en,
  input  logic                 cal_start,
  input  logic                 cal_abort,
  input  logic [1:0]           cal_ch,
  input  logic [3:0]           cal_len_log2,
  input  logic                 adc_valid,
  input  logic [ADC_WIDTH-1:0] adc_data_1,
  input  logic [ADC_WIDTH-1:0] adc_data_2,
  output logic                 adc_en,
  output logic                 param_wen,
  output logic [31:0]          zero_cal,
  output logic                 cal_busy,
  output logic                 cal_done,
  output logic                 cal_err
);

  localparam int ACC_W = ADC_WIDTH + 12;
  localparam int CNT_W = 13;
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 2);
  localparam int WD_W  = $clog2(TIMEOUT + 2);
  localparam logic [3:0] K_MAX = 4'd12;

  typedef enum logic [2:0] {IDLE, DRAIN, ACCUM, AVG, COMMIT} state_t;

  state_t               state;
  state_t               next_state;
  logic                 ch2_q;
  logic [3:0]           k_q;
  logic [DRN_W-1:0]     drain_cnt;
  logic [CNT_W-1:0]     sample_cnt;
  logic [WD_W-1:0]      wd_cnt;
  logic                 pend;
  logic [ADC_WIDTH-1:0] pend_data;
  logic [ACC_W-1:0]     acc;

  logic                 ch_ok;
  logic [3:0]           k_in;
  logic [CNT_W-1:0]     n_target;
  logic                 all_taken;
  logic                 capture;
  logic                 clr;
  logic                 commit_next;
  logic                 err_next;

  assign ch_ok     = (cal_ch == 2'd1) || (cal_ch == 2'd2);
  assign k_in      = (cal_len_log2 > K_MAX) ? K_MAX : cal_len_log2;
  assign n_target  = CNT_W'(1) << k_q;
  assign all_taken = (sample_cnt == n_target);

  // Samples are registered into pend/pend_data and summed one cycle later, so
  // the N-th sample leaves ACCUM one cycle after it is captured.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    next_state  = state;
    capture     = 1'b0;
    clr         = 1'b0;
    commit_next = 1'b0;
    err_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cal_start) begin
          if (ch_ok) begin
            next_state = DRAIN;
            clr        = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cal_abort) begin
          next_state = IDLE;
          err_next   = 1'b1;
        end else if (drain_cnt == DRN_W'(DRAIN_CYCLES - 1)) begin
          next_state = ACCUM;
        end
      end
      ACCUM: begin
        if (cal_abort) begin
          next_state = IDLE;
          err_next   = 1'b1;
        end else begin
          capture = adc_valid && !all_taken;
          if (pend && all_taken) begin
            next_state = AVG;
          end else if (!capture && (wd_cnt == WD_W'(TIMEOUT - 1))) begin
            next_state = IDLE;
            err_next   = 1'b1;
          end
        end
      end
      AVG: begin
        if (cal_abort) begin
          next_state = IDLE;
          err_next   = 1'b1;
        end else begin
          next_state  = COMMIT;
          commit_next = 1'b1;
        end
      end
      COMMIT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next-state decisions so each strobe lines up
  // with the state it belongs to.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state      <= IDLE;
      adc_en     <= 1'b0;
      param_wen  <= 1'b0;
      zero_cal   <= '0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_err    <= 1'b0;
      ch2_q      <= 1'b0;
      k_q        <= '0;
      drain_cnt  <= '0;
      sample_cnt <= '0;
      wd_cnt     <= '0;
      pend       <= 1'b0;
      pend_data  <= '0;
      acc        <= '0;
    end else begin
      state     <= next_state;
      cal_busy  <= (next_state != IDLE);
      adc_en    <= (next_state == IDLE) && run_en;
      param_wen <= commit_next;
      cal_done  <= commit_next;
      cal_err   <= err_next;
      if (commit_next) zero_cal <= 32'(acc >> k_q);

      pend <= capture;
      if (capture) pend_data <= ch2_q ? adc_data_2 : adc_data_1;

      if (clr) begin
        ch2_q      <= (cal_ch == 2'd2);
        k_q        <= k_in;
        drain_cnt  <= '0;
        sample_cnt <= '0;
        wd_cnt     <= '0;
        acc        <= '0;
      end else begin
        if (state == DRAIN) drain_cnt <= drain_cnt + DRN_W'(1);
        if (capture) sample_cnt <= sample_cnt + CNT_W'(1);
        if (pend) acc <= acc + ACC_W'(pend_data);
        if (capture) begin
          wd_cnt <= '0;
        end else if (state == ACCUM) begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end
    end
  end

  // Commit strobe integrity; synthesis ignores these.
  assert property (@(posedge clk) disable iff (rst) param_wen |-> state == COMMIT);
  assert property (@(posedge clk) disable iff (rst) param_wen |=> !param_wen);
  assert property (@(posedge clk) disable iff (rst) cal_busy == (state != IDLE));

endmodule

// File: tb/tb_adc_zero_cal_ctrl.sv
// Directed bench for adc_zero_cal_ctrl: one task per scenario, expected values
// hand-computed against cycle numbers counted from the cal_start cycle (cycle 0).
module tb_adc_zero_cal_ctrl;

  logic        clk;
  logic        rst;
  logic        run_en;
  logic        cal_start;
  logic        cal_abort;
  logic [1:0]  cal_ch;
  logic [3:0]  cal_len_log2;
  logic        adc_valid;
  logic [11:0] adc_data_1;
  logic [11:0] adc_data_2;
  logic        adc_en;
  logic        param_wen;
  logic [31:0] zero_cal;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_err;

  int errors = 0;
  int checks = 0;

  adc_zero_cal_ctrl #(
    .ADC_WIDTH   (12),
    .DRAIN_CYCLES(4),
    .TIMEOUT     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_en      (run_en),
    .cal_start   (cal_start),
    .cal_abort   (cal_abort),
    .cal_ch      (cal_ch),
    .cal_len_log2(cal_len_log2),
    .adc_valid   (adc_valid),
    .adc_data_1  (adc_data_1),
    .adc_data_2  (adc_data_2),
    .adc_en      (adc_en),
    .param_wen   (param_wen),
    .zero_cal    (zero_cal),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cal_err     (cal_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run_en = 1'b1; cal_start = 1'b0; cal_abort = 1'b0; cal_ch = 2'd0;
    cal_len_log2 = 4'd0; adc_valid = 1'b0; adc_data_1 = '0; adc_data_2 = '0;
    step(); step();
    checks++; if (adc_en !== 1'b0) begin errors++; $display("FAIL reset_adc_en: got %0b want 0", adc_en); end
    checks++; if (param_wen !== 1'b0) begin errors++; $display("FAIL reset_param_wen: got %0b want 0", param_wen); end
    checks++; if (zero_cal !== 32'd0) begin errors++; $display("FAIL reset_zero_cal: got %0h want 0", zero_cal); end
    checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", cal_busy); end
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", cal_done); end
    checks++; if (cal_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", cal_err); end
    rst = 1'b0;
    step();
    checks++; if (adc_en !== 1'b1) begin errors++; $display("FAIL reset_adc_en_follow: got %0b want 1", adc_en); end
  endtask

  // ch1, k=2, samples 100,101,102,105 -> 408/4 = 102, commit in cycle 4+4+3 = 11.
  task automatic test_basic();
    logic exp_wen, exp_busy, exp_en;
    logic [31:0] exp_zero;
    cal_start = 1'b1; cal_ch = 2'd1; cal_len_log2 = 4'd2; adc_valid = 1'b1;
    adc_data_1 = 12'd4000; adc_data_2 = 12'd7;
    for (int i = 1; i <= 16; i++) begin
      step();
      cal_start = 1'b0;
      case (i)
        5: adc_data_1 = 12'd100;
        6: adc_data_1 = 12'd101;
        7: adc_data_1 = 12'd102;
        8: adc_data_1 = 12'd105;
        9: adc_data_1 = 12'd3000;
        default: ;
      endcase
      exp_wen  = (i == 11);
      exp_busy = (i <= 11);
      exp_en   = (i >= 12);
      exp_zero = (i >= 11) ? 32'd102 : 32'd0;
      checks++; if (param_wen !== exp_wen) begin errors++; $display("FAIL basic_param_wen cyc %0d: got %0b want %0b", i, param_wen, exp_wen); end
      checks++; if (cal_done !== exp_wen) begin errors++; $display("FAIL basic_done cyc %0d: got %0b want %0b", i, cal_done, exp_wen); end
      checks++; if (cal_busy !== exp_busy) begin errors++; $display("FAIL basic_busy cyc %0d: got %0b want %0b", i, cal_busy, exp_busy); end
      checks++; if (adc_en !== exp_en) begin errors++; $display("FAIL basic_adc_en cyc %0d: got %0b want %0b", i, adc_en, exp_en); end
      checks++; if (zero_cal !== exp_zero) begin errors++; $display("FAIL basic_zero cyc %0d: got %0d want %0d", i, zero_cal, exp_zero); end
      checks++; if (cal_err !== 1'b0) begin errors++; $display("FAIL basic_err cyc %0d: got %0b want 0", i, cal_err); end
    end
  endtask

  // ch2, k=15 clamps to 12: 4096 samples of 0xFFF, commit in cycle 4+4096+3 = 4103.
  task automatic test_clamp();
    int wen_cycle, pulses, err_seen;
    logic [31:0] zero_at_wen;
    wen_cycle = -1; pulses = 0; err_seen = 0; zero_at_wen = '0;
    cal_start = 1'b1; cal_ch = 2'd2; cal_len_log2 = 4'd15; adc_valid = 1'b1;
    adc_data_1 = 12'd0; adc_data_2 = 12'hFFF;
    for (int i = 1; i <= 4110; i++) begin
      step();
      cal_start = 1'b0;
      if (param_wen === 1'b1) begin
        pulses++;
        if (wen_cycle < 0) begin
          wen_cycle   = i;
          zero_at_wen = zero_cal;
        end
      end
      if (cal_err === 1'b1) err_seen++;
    end
    checks++; if (wen_cycle != 4103) begin errors++; $display("FAIL clamp_latency: got %0d want 4103", wen_cycle); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL clamp_wen_pulses: got %0d want 1", pulses); end
    checks++; if (zero_at_wen !== 32'h0000_0FFF) begin errors++; $display("FAIL clamp_zero_at_wen: got %0h want fff", zero_at_wen); end
    checks++; if (zero_cal !== 32'h0000_0FFF) begin errors++; $display("FAIL clamp_zero: got %0h want fff", zero_cal); end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL clamp_err: got %0d want 0", err_seen); end
    checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL clamp_busy_end: got %0b want 0", cal_busy); end
  endtask

  task automatic test_bad_channel();
    logic [1:0] bad_chs [2];
    bad_chs[0] = 2'd0;
    bad_chs[1] = 2'd3;
    for (int j = 0; j < 2; j++) begin
      cal_start = 1'b1; cal_ch = bad_chs[j]; cal_len_log2 = 4'd2;
      step();
      cal_start = 1'b0;
      checks++; if (cal_err !== 1'b1) begin errors++; $display("FAIL badch%0d_err: got %0b want 1", bad_chs[j], cal_err); end
      checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL badch%0d_busy: got %0b want 0", bad_chs[j], cal_busy); end
      checks++; if (zero_cal !== 32'h0000_0FFF) begin errors++; $display("FAIL badch%0d_zero: got %0h want fff", bad_chs[j], zero_cal); end
      step();
      checks++; if (cal_err !== 1'b0) begin errors++; $display("FAIL badch%0d_err_single: got %0b want 0", bad_chs[j], cal_err); end
      checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL badch%0d_busy_after: got %0b want 0", bad_chs[j], cal_busy); end
    end
  endtask

  // k=4, samples captured in cycles 5..9, abort in cycle 10 -> cal_err in cycle 11.
  task automatic test_abort();
    logic exp_err, exp_busy;
    cal_start = 1'b1; cal_ch = 2'd1; cal_len_log2 = 4'd4; adc_valid = 1'b1;
    adc_data_1 = 12'd50; adc_data_2 = 12'd60;
    for (int i = 1; i <= 20; i++) begin
      step();
      cal_start = (i == 7);
      cal_abort = (i == 10);
      exp_err  = (i == 11);
      exp_busy = (i <= 10);
      checks++; if (cal_err !== exp_err) begin errors++; $display("FAIL abort_err cyc %0d: got %0b want %0b", i, cal_err, exp_err); end
      checks++; if (cal_busy !== exp_busy) begin errors++; $display("FAIL abort_busy cyc %0d: got %0b want %0b", i, cal_busy, exp_busy); end
      checks++; if (param_wen !== 1'b0) begin errors++; $display("FAIL abort_param_wen cyc %0d: got %0b want 0", i, param_wen); end
      checks++; if (zero_cal !== 32'h0000_0FFF) begin errors++; $display("FAIL abort_zero cyc %0d: got %0h want fff", i, zero_cal); end
    end
    cal_abort = 1'b0;
  endtask

  // Start while busy is ignored, abort during COMMIT is ignored, and start+abort
  // in IDLE starts a second run (ch2, k=1) that commits in cycle 12+4+2+3 = 21.
  task automatic test_back_to_back();
    logic exp_wen, exp_busy;
    logic [31:0] exp_zero;
    cal_start = 1'b1; cal_ch = 2'd1; cal_len_log2 = 4'd2; adc_valid = 1'b1;
    adc_data_1 = 12'd200; adc_data_2 = 12'd900;
    for (int i = 1; i <= 26; i++) begin
      step();
      cal_start = 1'b0; cal_abort = 1'b0;
      if (i == 6) begin cal_start = 1'b1; cal_ch = 2'd2; end
      if (i == 11) cal_abort = 1'b1;
      if (i == 12) begin cal_start = 1'b1; cal_ch = 2'd2; cal_len_log2 = 4'd1; cal_abort = 1'b1; end
      exp_wen  = (i == 11) || (i == 21);
      exp_busy = (i <= 11) || ((i >= 13) && (i <= 21));
      exp_zero = (i < 11) ? 32'h0000_0FFF : ((i < 21) ? 32'd200 : 32'd900);
      checks++; if (param_wen !== exp_wen) begin errors++; $display("FAIL b2b_param_wen cyc %0d: got %0b want %0b", i, param_wen, exp_wen); end
      checks++; if (cal_busy !== exp_busy) begin errors++; $display("FAIL b2b_busy cyc %0d: got %0b want %0b", i, cal_busy, exp_busy); end
      checks++; if (zero_cal !== exp_zero) begin errors++; $display("FAIL b2b_zero cyc %0d: got %0d want %0d", i, zero_cal, exp_zero); end
      checks++; if (cal_err !== 1'b0) begin errors++; $display("FAIL b2b_err cyc %0d: got %0b want 0", i, cal_err); end
    end
    cal_start = 1'b0; cal_abort = 1'b0;
  endtask

  // One sample in cycle 5, then idle from cycle 6: 16th idle cycle is 21, cal_err in 22.
  task automatic test_timeout();
    logic exp_err, exp_busy;
    cal_start = 1'b1; cal_ch = 2'd1; cal_len_log2 = 4'd2; adc_valid = 1'b0;
    adc_data_1 = 12'd77;
    for (int i = 1; i <= 30; i++) begin
      step();
      cal_start = 1'b0;
      adc_valid = (i == 5);
      exp_err  = (i == 22);
      exp_busy = (i <= 21);
      checks++; if (cal_err !== exp_err) begin errors++; $display("FAIL timeout_err cyc %0d: got %0b want %0b", i, cal_err, exp_err); end
      checks++; if (cal_busy !== exp_busy) begin errors++; $display("FAIL timeout_busy cyc %0d: got %0b want %0b", i, cal_busy, exp_busy); end
      checks++; if (param_wen !== 1'b0) begin errors++; $display("FAIL timeout_param_wen cyc %0d: got %0b want 0", i, param_wen); end
      checks++; if (zero_cal !== 32'd900) begin errors++; $display("FAIL timeout_zero cyc %0d: got %0d want 900", i, zero_cal); end
    end
  endtask

  // rst during ACCUM (cycle 7): everything at reset values in cycle 8, no pulses afterwards.
  task automatic test_reset_mid();
    cal_start = 1'b1; cal_ch = 2'd1; cal_len_log2 = 4'd3; adc_valid = 1'b1;
    adc_data_1 = 12'd10; run_en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      cal_start = 1'b0;
      rst = (i == 7);
      if (i == 8) begin
        checks++; if (adc_en !== 1'b0) begin errors++; $display("FAIL rstmid_adc_en: got %0b want 0", adc_en); end
        checks++; if (zero_cal !== 32'd0) begin errors++; $display("FAIL rstmid_zero: got %0d want 0", zero_cal); end
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b want 0", cal_busy); end
      end
      if (i == 9) begin
        checks++; if (adc_en !== 1'b1) begin errors++; $display("FAIL rstmid_adc_en_resume: got %0b want 1", adc_en); end
      end
      checks++; if (param_wen !== 1'b0) begin errors++; $display("FAIL rstmid_param_wen cyc %0d: got %0b want 0", i, param_wen); end
      checks++; if ((cal_done | cal_err) !== 1'b0) begin errors++; $display("FAIL rstmid_pulse cyc %0d: got done=%0b err=%0b want 0", i, cal_done, cal_err); end
      if (i >= 8) begin
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after cyc %0d: got %0b want 0", i, cal_busy); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_bad_channel();
    test_abort();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL tb_time_limit: simulation did not finish within 1 ms");
    $fatal(1, "time limit");
  end

endmodule
